// File: rtl/mul_div_unit_pkg.sv
// Shared MDU operation codes and decode helpers for mul_div_unit.
// MDU_MADD_EN: when defined, the multiply-accumulate codes are decoded as launch ops.
package mul_div_unit_pkg;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MTHI  = 4'd5;
  localparam logic [3:0] MD_MTLO  = 4'd6;
  localparam logic [3:0] MD_MFHI  = 4'd7;
  localparam logic [3:0] MD_MFLO  = 4'd8;
  localparam logic [3:0] MD_MADD  = 4'd9;
  localparam logic [3:0] MD_MADDU = 4'd10;
  localparam logic [3:0] MD_MSUB  = 4'd11;
  localparam logic [3:0] MD_MSUBU = 4'd12;

  // Operation captured at launch and held until commit.
  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } md_req_t;

  function automatic logic md_is_div(logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_launch(logic [3:0] op);
    logic l;
    l = (op == MD_MULT) || (op == MD_MULTU) || md_is_div(op);
`ifdef MDU_MADD_EN
    l = l || (op == MD_MADD) || (op == MD_MADDU) || (op == MD_MSUB) || (op == MD_MSUBU);
`endif
    return l;
  endfunction

endpackage

// File: rtl/mul_div_unit_md_calc.sv
// Combinational result generator for mul_div_unit: (op, a, b, hi, lo) -> {new_hi, new_lo, wr}.
// MDU_MADD_EN: when defined, also evaluates madd/maddu/msub/msubu against the current HI/LO.
module md_calc
  import mul_div_unit_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [31:0] new_hi,
  output logic [31:0] new_lo,
  output logic        wr
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;

  assign prod_s = 64'($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}));
  assign prod_u = {32'd0, a} * {32'd0, b};

  always_comb begin
    new_hi = hi;
    new_lo = lo;
    wr     = 1'b0;
    case (op)
      MD_MULT: begin
        {new_hi, new_lo} = prod_s;
        wr = 1'b1;
      end
      MD_MULTU: begin
        {new_hi, new_lo} = prod_u;
        wr = 1'b1;
      end
      MD_DIV: begin
        if (b != 32'd0) begin
          wr = 1'b1;
          // Most-negative / -1 overflows; pin the architectural answer explicitly.
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            new_lo = 32'h8000_0000;
            new_hi = 32'd0;
          end else begin
            new_lo = 32'($signed(a) / $signed(b));
            new_hi = 32'($signed(a) % $signed(b));
          end
        end
      end
      MD_DIVU: begin
        if (b != 32'd0) begin
          wr     = 1'b1;
          new_lo = a / b;
          new_hi = a % b;
        end
      end
`ifdef MDU_MADD_EN
      MD_MADD: begin
        {new_hi, new_lo} = {hi, lo} + prod_s;
        wr = 1'b1;
      end
      MD_MADDU: begin
        {new_hi, new_lo} = {hi, lo} + prod_u;
        wr = 1'b1;
      end
      MD_MSUB: begin
        {new_hi, new_lo} = {hi, lo} - prod_s;
        wr = 1'b1;
      end
      MD_MSUBU: begin
        {new_hi, new_lo} = {hi, lo} - prod_u;
        wr = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the Execute stage.
// MDU_MADD_EN: when defined, enables the madd/maddu/msub/msubu multiply-accumulate ops.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  md_op,
  input  logic        start,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic [31:0] md_res,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  md_req_t         req_q, req_d;
  logic [31:0]     hi_q, hi_d, lo_q, lo_d;
  logic [31:0]     calc_hi, calc_lo;
  logic            calc_wr;
  logic            launch;

  assign busy   = (cnt_q != '0);
  assign launch = start && !busy && md_is_launch(md_op);
  assign hi     = hi_q;
  assign lo     = lo_q;

  md_calc u_md_calc (
    .op     (req_q.op),
    .a      (req_q.a),
    .b      (req_q.b),
    .hi     (hi_q),
    .lo     (lo_q),
    .new_hi (calc_hi),
    .new_lo (calc_lo),
    .wr     (calc_wr)
  );

  always_comb begin
    cnt_d = cnt_q;
    req_d = req_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    if (launch) begin
      req_d = '{op: md_op, a: rs_val, b: rt_val};
      cnt_d = md_is_div(md_op) ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
    end else if (busy) begin
      cnt_d = cnt_q - CntW'(1);
      // Commit on the edge where the counter reaches zero, so busy and HI/LO change together.
      if (cnt_q == CntW'(1) && calc_wr) begin
        hi_d = calc_hi;
        lo_d = calc_lo;
      end
    end else if (md_op == MD_MTHI) begin
      hi_d = rs_val;
    end else if (md_op == MD_MTLO) begin
      lo_d = rs_val;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      req_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      req_q <= req_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end

  always_comb begin
    md_res = 32'd0;
    if (md_op == MD_MFHI) begin
      md_res = hi_q;
    end else if (md_op == MD_MFLO) begin
      md_res = lo_q;
    end
  end

endmodule
